mult_feed_ctrl: RTL and testbench
=================================

// Module: mult_feed_ctrl
// PURPOSE
//  - Host-side sequencer for the 3x3 output-stationary systolic multiplier array (C = A x B).
//  - Buffers A and B from a load port, clears the array, and drives skewed a1..a3 / b1..b3 streams.
//  - Captures c1..c9 once the array settles, then streams the 9 results out with valid/ready.
// PARAMETERS
//  - DATA_SIZE  8  element width of A and B; result width RW = 2*DATA_SIZE+1 (17 at default)
// PORTS
//  clk        in   1       clock, all logic rising-edge
//  reset      in   1       synchronous, active-high
//  ld_valid   in   1       load element offered
//  ld_ready   out  1       load element accepted (1 only in IDLE)
//  ld_mat     in   1       0 = A, 1 = B
//  ld_row     in   2       row 0..2 (3 = ignored, still handshaken)
//  ld_col     in   2       col 0..2 (3 = ignored, still handshaken)
//  ld_data    in   DATA_SIZE  element value
//  start      in   1       begin a job (sampled in IDLE only)
//  busy       out  1       1 in every state except IDLE
//  arr_clr    out  1       drives array reset; 1 only in CLR
//  arr_a1..3  out  DATA_SIZE  row streams into array column 0
//  arr_b1..3  out  DATA_SIZE  column streams into array row 0
//  arr_c1..9  in   RW      array accumulators, row-major (c1 = C[0][0], c9 = C[2][2])
//  res_valid  out  1       result element valid
//  res_ready  in   1       result element consumed
//  res_idx    out  4       result index 0..8, row-major
//  res_data   out  RW      result value
// BEHAVIOUR
//  - Reset: state IDLE, t=0, res_idx=0, res_valid=0, busy=0, arr_clr=0, arr_a*/arr_b*=0.
//    A/B buffers are not cleared; they are zeroed only by explicit loads.
//  - All outputs are decoded from registers only; no combinational path from any input to any output.
//  - FSM: IDLE -> CLR -> FEED -> CAP -> OUT -> IDLE.
//    - IDLE: ld_ready=1; a load writes on the edge where ld_valid=1. start=1 -> CLR.
//      If start and ld_valid are both 1, the load is written and the job uses the new value.
//    - CLR: 1 cycle; arr_clr=1, streams 0.
//    - FEED: t = 0..6 (7 cycles), then CAP.
//      arr_a(i+1) = A[i][t-i] when 0 <= t-i <= 2, else 0.
//      arr_b(j+1) = B[t-j][j] when 0 <= t-j <= 2, else 0.
//      PE(i,j) accumulates k = t'-i-j; its last update is on the edge ending t=6.
//    - CAP: 1 cycle; latches arr_c1..9 into result regs; streams 0; res_idx <- 0.
//    - OUT: res_valid=1 and res_data = result[res_idx]; res_idx increments on valid&&ready.
//      After the transfer of idx 8, go to IDLE and set res_valid=0 on the same edge.
//  - start outside IDLE is ignored; it is not queued.
//  - ld_valid outside IDLE sees ld_ready=0 and nothing is written.
//  - res_ready held low in OUT: data and idx stay stable indefinitely, with no timeout.
//  - Arithmetic: results pass through unmodified at RW bits.
//    The array wraps mod 2^RW; the block adds no saturation or overflow flag.
//  - reset mid-job: immediate return to reset values; the array is cleared by the next job's CLR.
// CONFIGURATION
//  - MULT_FEED_JOBCNT_EN defined:
//    - adds output job_cnt [15:0], reset 0.
//    - increments on the final result transfer (idx 8) and wraps 0xFFFF -> 0.
//  - MULT_FEED_JOBCNT_EN undefined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package mult_feed_pkg holds:
//    - state enum {IDLE, CLR, FEED, CAP, OUT};
//    - localparam N=3, FEED_CYCLES=3*N-2 (=7), RES_CNT=N*N (=9);
//    - RW derivation function.
//  - One sub-module, mult_skew_sel: combinational; given t, lane index and a 3-element lane,
//    returns the element or 0. Six instances: 3 A rows, 3 B columns.
//  - Top level holds the FSM, t counter, A/B register files, result regs and output handshake.
// TESTING
//  - Scenarios:
//    - A = I, B = {1..9} row-major, start -> res 0..8 = 1..9; busy from start+1 until final transfer.
//    - A = B = {1..9} -> res = 30,36,42,66,81,96,102,126,150.
//    - All elements 255 -> every res = 195075 mod 2^17 = 64003 (wrap check).
//    - res_ready low 5 cycles at idx 4 -> res_idx/res_data held; then idx 5..8 follow, one per ready cycle.
//  - Sequencing checks:
//    - start in FEED plus ld_valid in OUT -> both ignored; buffers and results unchanged.
//    - reset asserted in FEED t=3 -> all outputs at reset values next cycle;
//      a rerun start gives a correct result.
//    - Check arr_a/arr_b values per FEED cycle against the skew table, and arr_clr=1 exactly 1 cycle.
//  - With MULT_FEED_JOBCNT_EN: run 3 jobs back-to-back -> job_cnt = 3.

Source files
------------

// File: rtl/mult_feed_pkg.sv
// Shared types and constants for the 3x3 systolic multiplier feed controller.
// The optional job counter is enabled with the MULT_FEED_JOBCNT_EN macro (see mult_feed_ctrl).
package mult_feed_pkg;

  typedef enum logic [2:0] {IDLE, CLR, FEED, CAP, OUT} state_t;

  localparam int N           = 3;
  localparam int FEED_CYCLES = 3*N - 2;
  localparam int RES_CNT     = N*N;

  // Result width: a 3-term dot product of DATA_SIZE operands, kept modulo 2^RW.
  function automatic int rw_of(input int data_size);
    return 2*data_size + 1;
  endfunction

endpackage

// File: rtl/mult_skew_sel.sv
// Skew selector: picks element (t - lane) of a 3-element lane, or 0 when t is outside
// the lane's active window.
module mult_skew_sel
  import mult_feed_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic [2:0]           t,
  input  logic [1:0]           lane,
  input  logic [DATA_SIZE-1:0] elems [N],
  output logic [DATA_SIZE-1:0] sel
);

  logic [3:0] k;

  always_comb begin
    sel = '0;
    k   = {1'b0, t} - {2'b00, lane};
    if (t >= {1'b0, lane}) begin
      case (k)
        4'd0:    sel = elems[0];
        4'd1:    sel = elems[1];
        4'd2:    sel = elems[2];
        default: sel = '0;
      endcase
    end
  end

endmodule

// File: rtl/mult_feed_ctrl.sv
// Host-side sequencer for a 3x3 output-stationary systolic multiplier: load A/B, clear,
// feed skewed streams, capture C, stream results. Define MULT_FEED_JOBCNT_EN to add job_cnt.
module mult_feed_ctrl
  import mult_feed_pkg::*;
#(
  parameter  int DATA_SIZE = 8,
  localparam int RW        = rw_of(DATA_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic                 ld_mat,
  input  logic [1:0]           ld_row,
  input  logic [1:0]           ld_col,
  input  logic [DATA_SIZE-1:0] ld_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 arr_clr,
  output logic [DATA_SIZE-1:0] arr_a1,
  output logic [DATA_SIZE-1:0] arr_a2,
  output logic [DATA_SIZE-1:0] arr_a3,
  output logic [DATA_SIZE-1:0] arr_b1,
  output logic [DATA_SIZE-1:0] arr_b2,
  output logic [DATA_SIZE-1:0] arr_b3,
  input  logic [RW-1:0]        arr_c1,
  input  logic [RW-1:0]        arr_c2,
  input  logic [RW-1:0]        arr_c3,
  input  logic [RW-1:0]        arr_c4,
  input  logic [RW-1:0]        arr_c5,
  input  logic [RW-1:0]        arr_c6,
  input  logic [RW-1:0]        arr_c7,
  input  logic [RW-1:0]        arr_c8,
  input  logic [RW-1:0]        arr_c9,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [3:0]           res_idx,
  output logic [RW-1:0]        res_data,
`ifdef MULT_FEED_JOBCNT_EN
  output logic [15:0]          job_cnt,
`endif
  output state_t               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // ld_ready and res_valid come straight from the state register, never from inputs.

  localparam logic [2:0] T_LAST   = 3'(FEED_CYCLES - 1);
  localparam logic [3:0] IDX_LAST = 4'(RES_CNT - 1);

  state_t               state_q, state_d;
  logic [2:0]           t_q, t_d;
  logic [DATA_SIZE-1:0] a_mem [N][N];
  logic [DATA_SIZE-1:0] b_mem [N][N];
  logic [RW-1:0]        res_mem [RES_CNT];
  logic [3:0]           res_idx_q;
  logic [DATA_SIZE-1:0] a_sel [N];
  logic [DATA_SIZE-1:0] b_sel [N];
  logic [DATA_SIZE-1:0] a_q [N];
  logic [DATA_SIZE-1:0] b_q [N];
  logic                 last_xfer;

  assign last_xfer = (state_q == OUT) && res_ready && (res_idx_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: if (start) state_d = CLR;
      CLR: begin
        state_d = FEED;
        t_d     = 3'd0;
      end
      FEED: begin
        if (t_q == T_LAST) state_d = CAP;
        else               t_d     = t_q + 3'd1;
      end
      CAP:  state_d = OUT;
      OUT:  if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // Operand buffers keep their contents across reset; only loads change them.
  always_ff @(posedge clk) begin
    if (!reset && state_q == IDLE && ld_valid && ld_row != 2'd3 && ld_col != 2'd3) begin
      if (ld_mat) b_mem[ld_row][ld_col] <= ld_data;
      else        a_mem[ld_row][ld_col] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CAP) begin
      res_mem[0] <= arr_c1;
      res_mem[1] <= arr_c2;
      res_mem[2] <= arr_c3;
      res_mem[3] <= arr_c4;
      res_mem[4] <= arr_c5;
      res_mem[5] <= arr_c6;
      res_mem[6] <= arr_c7;
      res_mem[7] <= arr_c8;
      res_mem[8] <= arr_c9;
    end
  end

  // Streams are registered from the next t so the array sees them during that FEED cycle.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_SIZE-1:0] a_row [N];
    logic [DATA_SIZE-1:0] b_col [N];
    for (genvar k = 0; k < N; k++) begin : g_el
      assign a_row[k] = a_mem[i][k];
      assign b_col[k] = b_mem[k][i];
    end
    mult_skew_sel #(.DATA_SIZE(DATA_SIZE)) u_a_sel (
      .t(t_d), .lane(2'(i)), .elems(a_row), .sel(a_sel[i])
    );
    mult_skew_sel #(.DATA_SIZE(DATA_SIZE)) u_b_sel (
      .t(t_d), .lane(2'(i)), .elems(b_col), .sel(b_sel[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_idx_q <= 4'd0;
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      if (state_q == CAP)
        res_idx_q <= 4'd0;
      else if (state_q == OUT && res_ready)
        res_idx_q <= last_xfer ? 4'd0 : res_idx_q + 4'd1;
      for (int i = 0; i < N; i++) begin
        a_q[i] <= (state_d == FEED) ? a_sel[i] : '0;
        b_q[i] <= (state_d == FEED) ? b_sel[i] : '0;
      end
    end
  end

`ifdef MULT_FEED_JOBCNT_EN
  always_ff @(posedge clk) begin
    if (reset)          job_cnt <= 16'd0;
    else if (last_xfer) job_cnt <= job_cnt + 16'd1;
  end
`endif

  assign ld_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign arr_clr   = (state_q == CLR);
  assign res_valid = (state_q == OUT);
  assign res_idx   = res_idx_q;
  assign res_data  = res_mem[res_idx_q];
  assign arr_a1    = a_q[0];
  assign arr_a2    = a_q[1];
  assign arr_a3    = a_q[2];
  assign arr_b1    = b_q[0];
  assign arr_b2    = b_q[1];
  assign arr_b3    = b_q[2];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_feed_ctrl.sv
// Bench for mult_feed_ctrl: emulated 3x3 systolic array, job-level reference model,
// per-cycle compare process, transfer scoreboard and literal result tables.
module tb_mult_feed_ctrl;
  import mult_feed_pkg::*;

  localparam int DS = 8;
  localparam int RW = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_valid = 1'b0, ld_ready, ld_mat = 1'b0;
  logic [1:0]    ld_row = 2'd0, ld_col = 2'd0;
  logic [DS-1:0] ld_data = '0;
  logic          start = 1'b0, busy, arr_clr;
  logic [DS-1:0] arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3;
  logic [RW-1:0] arr_c1, arr_c2, arr_c3, arr_c4, arr_c5, arr_c6, arr_c7, arr_c8, arr_c9;
  logic          res_valid, res_ready = 1'b0;
  logic [3:0]    res_idx;
  logic [RW-1:0] res_data;
  state_t        dbg_state;
`ifdef MULT_FEED_JOBCNT_EN
  logic [15:0]   job_cnt;
`endif

  mult_feed_ctrl #(.DATA_SIZE(DS)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_mat(ld_mat),
    .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data), .start(start), .busy(busy),
    .arr_clr(arr_clr), .arr_a1(arr_a1), .arr_a2(arr_a2), .arr_a3(arr_a3),
    .arr_b1(arr_b1), .arr_b2(arr_b2), .arr_b3(arr_b3),
    .arr_c1(arr_c1), .arr_c2(arr_c2), .arr_c3(arr_c3), .arr_c4(arr_c4), .arr_c5(arr_c5),
    .arr_c6(arr_c6), .arr_c7(arr_c7), .arr_c8(arr_c8), .arr_c9(arr_c9),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
`ifdef MULT_FEED_JOBCNT_EN
    .job_cnt(job_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- emulated systolic array ----------------
  logic [DS-1:0] a_in_v [3];
  logic [DS-1:0] b_in_v [3];
  logic [RW-1:0] acc [3][3];
  logic [DS-1:0] ap [3][3];
  logic [DS-1:0] bp [3][3];

  assign a_in_v[0] = arr_a1; assign a_in_v[1] = arr_a2; assign a_in_v[2] = arr_a3;
  assign b_in_v[0] = arr_b1; assign b_in_v[1] = arr_b2; assign b_in_v[2] = arr_b3;
  assign arr_c1 = acc[0][0]; assign arr_c2 = acc[0][1]; assign arr_c3 = acc[0][2];
  assign arr_c4 = acc[1][0]; assign arr_c5 = acc[1][1]; assign arr_c6 = acc[1][2];
  assign arr_c7 = acc[2][0]; assign arr_c8 = acc[2][1]; assign arr_c9 = acc[2][2];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        logic [DS-1:0] ain, bin;
        ain = (j == 0) ? a_in_v[i] : ap[i][j-1];
        bin = (i == 0) ? b_in_v[j] : bp[i-1][j];
        if (arr_clr) begin
          acc[i][j] <= '0;
          ap[i][j]  <= '0;
          bp[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + RW'(ain * bin);
          ap[i][j]  <= ain;
          bp[i][j]  <= bin;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // m_cyc counts cycles since start was accepted: 1 clear, 2..8 feed (t = m_cyc-2), 9 capture, 10 output.
  int            sh_a [3][3];
  int            sh_b [3][3];
  bit            m_active = 1'b0;
  int            m_cyc = 0;
  int            m_idx = 0;
  int            m_jobs = 0;
  logic [RW-1:0] m_res [9];
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] got_q [$];

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_cyc    = 0;
      m_idx    = 0;
      m_jobs   = 0;
      exp_q.delete();
    end else if (!m_active) begin
      if (ld_valid && ld_row < 3 && ld_col < 3) begin
        if (ld_mat) sh_b[ld_row][ld_col] = int'(ld_data);
        else        sh_a[ld_row][ld_col] = int'(ld_data);
      end
      if (start) begin
        m_active = 1'b1;
        m_cyc    = 1;
        m_idx    = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < 3; k++) s += sh_a[i][k] * sh_b[k][j];
            m_res[i*3+j] = s[RW-1:0];
            exp_q.push_back(s[RW-1:0]);
          end
        end
      end
    end else if (m_cyc < 10) begin
      m_cyc++;
    end else if (res_ready) begin
      if (m_idx == 8) begin
        m_active = 1'b0;
        m_idx    = 0;
        m_jobs   = (m_jobs + 1) % 65536;
      end else begin
        m_idx++;
      end
    end
  end

  // ---------------- scoreboard on result transfers ----------------
  always @(posedge clk) begin
    if (cmp_on && !reset && res_valid && res_ready) begin
      got_q.push_back(res_data);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected actual=%0d required=none at %0t", res_data, $time);
      end else begin
        chk("xfer_data", res_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      int t;
      bit feeding;
      logic [DS-1:0] ea, eb;
      t = m_cyc - 2;
      feeding = m_active && m_cyc >= 2 && m_cyc <= 8;
      chk("busy", busy, m_active);
      chk("ld_ready", ld_ready, !m_active);
      chk("arr_clr", arr_clr, m_active && m_cyc == 1);
      chk("res_valid", res_valid, m_active && m_cyc == 10);
      for (int i = 0; i < 3; i++) begin
        ea = '0;
        eb = '0;
        if (feeding && t - i >= 0 && t - i <= 2) begin
          ea = sh_a[i][t-i][DS-1:0];
          eb = sh_b[t-i][i][DS-1:0];
        end
        chk("arr_a", a_in_v[i], ea);
        chk("arr_b", b_in_v[i], eb);
      end
      if (m_active && m_cyc == 10) begin
        chk("res_idx", res_idx, m_idx);
        chk("res_data", res_data, m_res[m_idx]);
      end
`ifdef MULT_FEED_JOBCNT_EN
      chk("job_cnt", job_cnt, m_jobs);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_elem(input bit mat, input int row, input int col, input int data);
    ld_valid = 1'b1;
    ld_mat   = mat;
    ld_row   = row[1:0];
    ld_col   = col[1:0];
    ld_data  = data[DS-1:0];
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic load_all(input int a [9], input int b [9]);
    for (int k = 0; k < 9; k++) load_elem(1'b0, k / 3, k % 3, a[k]);
    for (int k = 0; k < 9; k++) load_elem(1'b1, k / 3, k % 3, b[k]);
  endtask

  // stray=1 pulses start during FEED and offers loads during OUT; both must be ignored.
  task automatic run_job(input int pct, input bit stray);
    int n;
    n = 0;
    got_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (got_q.size() < 9 && n < 300) begin
      n++;
      res_ready = ($urandom_range(0, 99) < pct);
      start     = stray && (n == 4);
      if (stray && n >= 12 && n < 16) begin
        ld_valid  = 1'b1;
        ld_mat    = n[0];
        ld_row    = 2'd0;
        ld_col    = 2'd0;
        ld_data   = 8'hAA;
        res_ready = 1'b0;
      end else begin
        ld_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    ld_valid  = 1'b0;
    res_ready = 1'b0;
    chk("job_done", got_q.size(), 9);
  endtask

  task automatic chk_lit(input string name, input int exp [9]);
    for (int i = 0; i < 9; i++) begin
      if (i < got_q.size()) chk(name, got_q[i], exp[i]);
      else                  chk(name, 32'hFFFF_FFFF, exp[i]);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_ld_ready"}, ld_ready, 1);
    chk({name, "_arr_clr"}, arr_clr, 0);
    chk({name, "_res_valid"}, res_valid, 0);
    chk({name, "_res_idx"}, res_idx, 0);
    chk({name, "_state"}, dbg_state, IDLE);
    for (int i = 0; i < 3; i++) begin
      chk({name, "_arr_a"}, a_in_v[i], 0);
      chk({name, "_arr_b"}, b_in_v[i], 0);
    end
  endtask

  int m_ident [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int m_seq   [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int m_full  [9] = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
  int r_sq    [9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
  int r_wrap  [9] = '{64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003};

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int ra [9];
    int rb [9];

    reset = 1'b1;
    @(posedge clk);
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_outputs("reset");

    // identity times sequence, plus an out-of-range load that must be dropped
    load_all(m_ident, m_seq);
    load_elem(1'b0, 3, 1, 99);
    load_elem(1'b1, 1, 3, 99);
    run_job(100, 1'b0);
    chk_lit("ident", m_seq);

    load_all(m_seq, m_seq);
    run_job(60, 1'b0);
    chk_lit("square", r_sq);

    load_all(m_full, m_full);
    run_job(70, 1'b0);
    chk_lit("wrap", r_wrap);

    // backpressure at index 4
    load_all(m_seq, m_seq);
    got_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while (!(res_valid && res_idx == 4) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_reached", n < 100, 1);
    res_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_idx", res_idx, 4);
      chk("stall_data", res_data, 81);
    end
    chk("stall_count", got_q.size(), 4);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("burst_count", got_q.size(), 5 + k);
    end
    res_ready = 1'b0;
    chk_lit("burst", r_sq);

    // stray start in FEED and loads in OUT
    load_all(m_ident, m_seq);
    run_job(50, 1'b1);
    chk_lit("stray", m_seq);
    run_job(100, 1'b0);
    chk_lit("stray_rerun", m_seq);

    // reset during FEED t=3
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_outputs("midreset");
    run_job(100, 1'b0);
    chk_lit("after_reset", m_seq);

    // randomized jobs against the model
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 9; k++) begin
        ra[k] = $urandom_range(0, 255);
        rb[k] = $urandom_range(0, 255);
      end
      load_all(ra, rb);
      run_job($urandom_range(30, 100), j[0]);
    end

`ifdef MULT_FEED_JOBCNT_EN
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("jobcnt_reset", job_cnt, 0);
    for (int j = 0; j < 3; j++) run_job(100, 1'b0);
    chk("jobcnt_three", job_cnt, 3);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
